prog_memory_ctrl: RTL and testbench
===================================

Name: prog_memory_ctrl

Overview:
Parametrised successor to the CPU's 16x4 register memory. Adds configurable width and depth, a registered read port with a valid flag, and a sequential program-loader state machine. The loader lets an external host stream a program into memory after reset without using the CPU write port. It sits between the CPU core (fetch, LD and ST) and the top-level I/O pins used for program download.

Parameters:
DATA_WIDTH, 4, bits per word
DEPTH, 16, number of words (2..2**ADDR_WIDTH)
ADDR_WIDTH, 4, address bits

Ports:
clk_i  in  1  system clock, rising edge
reset_i  in  1  synchronous, active-high reset
write_en_i  in  1  CPU write strobe
read_en_i  in  1  CPU read strobe
addr_i  in  ADDR_WIDTH  CPU address
data_i  in  DATA_WIDTH  CPU write data
data_o  out  DATA_WIDTH  registered read data
data_valid_o  out  1  data_o holds the result of the previous cycle's read
load_start_i  in  1  begins a program download at address 0
load_valid_i  in  1  load_data_i is valid
load_data_i  in  DATA_WIDTH  download word
load_ready_o  out  1  loader accepts a word this cycle
load_busy_o  out  1  loader active; CPU port locked out
load_done_o  out  1  one-cycle pulse after the last word is written

Behaviour:
- Clock and reset: one clock, clk_i; reset_i is synchronous and active-high. All state changes happen on the rising edge of clk_i.
- Reset (synchronous, evaluated at the edge):
  - mem[0]=4'hE (OUT), mem[1]=4'h5 (INC), mem[2]=4'h8 (JMP), mem[3]=0; all other words 0.
  - Init values are zero-extended, or truncated to their LSBs, to DATA_WIDTH.
  - Loader state goes to IDLE and load_addr to 0.
  - data_o=0, data_valid_o=0, load_ready_o=0, load_busy_o=0, load_done_o=0.
- Reset mid-download: abandons the load. Words already written are overwritten by the init program.
- CPU read, 1-cycle latency:
  - read_en_i=1 at edge N gives data_o=mem[addr_i] and data_valid_o=1 from edge N until edge N+1.
  - read_en_i=0 gives data_o=0 and data_valid_o=0 at the next edge.
- CPU write: write_en_i=1 writes data_i into mem[addr_i] at the edge.
- Same-address read and write in one cycle: read returns the old data (read-before-write).
- addr_i >= DEPTH: write is dropped; read returns 0 with data_valid_o=1.
- Loader FSM states: IDLE and LOAD.
  - IDLE -> LOAD on load_start_i=1. load_addr is set to 0.
  - In LOAD: load_ready_o=1 and load_busy_o=1 (registered, asserted from the cycle after start).
  - Each cycle with load_valid_i & load_ready_o writes load_data_i to mem[load_addr] and increments load_addr.
  - Accepting the word at load_addr==DEPTH-1: return to IDLE and pulse load_done_o for exactly one cycle on the following cycle; load_addr returns to 0.
  - load_start_i while in LOAD is ignored (no restart).
  - load_valid_i while in IDLE is ignored.
  - load_valid_i=0 in LOAD stalls indefinitely; no timeout.
- CPU lockout while load_busy_o=1:
  - write_en_i is ignored.
  - read_en_i yields data_o=0 and data_valid_o=0.
  - Locked-out accesses are dropped, not queued.
- Priority: reset_i > loader write > CPU write.

Optional Feature:
- Macro name: PROG_MEMORY_PARITY_EN.
- When defined:
  - Each word stores one extra even-parity bit, computed on every CPU or loader write and reset to match the init values.
  - New output parity_err_o (1 bit, registered): asserted alongside data_valid_o when the stored parity mismatches the read word; otherwise 0.
  - Reset value of parity_err_o is 0.
  - Out-of-range reads report parity_err_o=0.
- When undefined: no parity storage, and the parity_err_o port does not exist.

Test Plan:
- Reset, then read addresses 0..4 -> data_o = E,5,8,0,0, each with data_valid_o=1 one cycle after the request.
- Write 0xA to addr 7, then read addr 7 -> 0xA. Write 0x3 to addr 7 with a simultaneous read of addr 7 -> read returns 0xA; the next read returns 0x3.
- load_start_i pulse, then stream 16 words 0..F with load_valid_i gaps -> load_busy_o high throughout, load_done_o high for exactly 1 cycle after the 16th word, and mem[i]=i on readback.
- During the load: CPU write 0x9 to addr 2 and a CPU read -> write has no effect, data_valid_o=0. Also a second load_start_i is ignored and load_addr keeps advancing.
- Assert reset_i after 5 of 16 words are loaded -> FSM returns to IDLE, load_busy_o=0, memory equals the init program.
- With PROG_MEMORY_PARITY_EN: force a stored bit flip at addr 1 through a bench hierarchical write, then read addr 1 -> parity_err_o=1; reading addr 0 -> parity_err_o=0.

Source files
------------

// File: rtl/prog_memory_ctrl.sv
// Program memory with CPU read/write port, registered read data and a streaming program loader.
// Latency: CPU reads return one cycle after the request; loader writes land at the accepting edge.
// Backpressure: load_ready_o gates host words; CPU port is locked out (accesses dropped) while loading.
// Optional even-parity per word is enabled by defining PROG_MEMORY_PARITY_EN (adds parity_err_o).
module prog_memory_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  write_en_i,
  input  logic                  read_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  input  logic                  load_start_i,
  input  logic                  load_valid_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  output logic                  load_ready_o,
  output logic                  load_busy_o,
  output logic                  load_done_o
`ifdef PROG_MEMORY_PARITY_EN
  ,
  output logic                  parity_err_o
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   load_addr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic in_range;
  logic loader_wr;
  logic last_word;
  logic cpu_wr;
  logic cpu_rd;

  // Boot program restored on every reset: OUT, INC, JMP, then zeros.
  function automatic logic [DATA_WIDTH-1:0] init_word(input int idx);
    case (idx)
      0:       init_word = DATA_WIDTH'(4'hE);
      1:       init_word = DATA_WIDTH'(4'h5);
      2:       init_word = DATA_WIDTH'(4'h8);
      default: init_word = '0;
    endcase
  endfunction

  // Widen before comparing so DEPTH == 2**ADDR_WIDTH does not collapse to a constant.
  assign in_range  = (32'(addr_i) < 32'(DEPTH));
  // load_ready_o is only high in LOAD, so it qualifies the host handshake directly.
  assign loader_wr = load_ready_o & load_valid_i;
  assign last_word = (load_addr == ADDR_WIDTH'(DEPTH - 1));
  assign cpu_wr    = write_en_i & ~load_busy_o & in_range;
  assign cpu_rd    = read_en_i & ~load_busy_o;

  // Loader FSM with registered handshake/status outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= IDLE;
      load_addr    <= '0;
      load_ready_o <= 1'b0;
      load_busy_o  <= 1'b0;
      load_done_o  <= 1'b0;
    end else begin
      load_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start_i) begin
            state        <= LOAD;
            load_addr    <= '0;
            load_ready_o <= 1'b1;
            load_busy_o  <= 1'b1;
          end
        end
        LOAD: begin
          // A new start request is deliberately ignored here; the download runs to completion.
          if (load_valid_i) begin
            if (last_word) begin
              state        <= IDLE;
              load_addr    <= '0;
              load_ready_o <= 1'b0;
              load_busy_o  <= 1'b0;
              load_done_o  <= 1'b1;
            end else begin
              load_addr <= load_addr + 1'b1;
            end
          end
        end
        default: begin
          state        <= IDLE;
          load_addr    <= '0;
          load_ready_o <= 1'b0;
          load_busy_o  <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: reset reloads the boot program, loader writes win over CPU writes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= init_word(i);
      end
    end else if (loader_wr) begin
      mem[load_addr] <= load_data_i;
    end else if (cpu_wr) begin
      mem[addr_i] <= data_i;
    end
  end

  // Registered read port; nonblocking update of mem gives read-before-write on a shared address.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_o       <= '0;
      data_valid_o <= 1'b0;
    end else if (cpu_rd) begin
      data_o       <= in_range ? mem[addr_i] : '0;
      data_valid_o <= 1'b1;
    end else begin
      data_o       <= '0;
      data_valid_o <= 1'b0;
    end
  end

`ifdef PROG_MEMORY_PARITY_EN
  logic par_mem [DEPTH];

  // Even-parity shadow bit per word, kept in step with every write path.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_mem[i] <= ^init_word(i);
      end
    end else if (loader_wr) begin
      par_mem[load_addr] <= ^load_data_i;
    end else if (cpu_wr) begin
      par_mem[addr_i] <= ^data_i;
    end
  end

  // Parity check on the word being read; out-of-range reads never flag an error.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      parity_err_o <= 1'b0;
    end else if (cpu_rd && in_range) begin
      parity_err_o <= (par_mem[addr_i] != ^mem[addr_i]);
    end else begin
      parity_err_o <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_prog_memory_ctrl.sv
// Scoreboard bench for prog_memory_ctrl: directed scenarios plus randomized traffic.
// Latency: one expected entry per clock edge, compared at the following falling edge.
// Backpressure: the model tracks loader state to predict ready/busy/done and CPU lockout.
module tb_prog_memory_ctrl;
  localparam int DW  = 4;
  localparam int AW  = 4;
  localparam int DEP = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, we, rd, st, lv;
  logic [AW-1:0] addr;
  logic [DW-1:0] din, ld;
  logic [DW-1:0] dout;
  logic          dvalid, lready, lbusy, ldone, perr;

`ifdef PROG_MEMORY_PARITY_EN
  prog_memory_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEP), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .reset_i(reset), .write_en_i(we), .read_en_i(rd), .addr_i(addr),
    .data_i(din), .data_o(dout), .data_valid_o(dvalid), .load_start_i(st),
    .load_valid_i(lv), .load_data_i(ld), .load_ready_o(lready), .load_busy_o(lbusy),
    .load_done_o(ldone), .parity_err_o(perr)
  );
`else
  prog_memory_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEP), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .reset_i(reset), .write_en_i(we), .read_en_i(rd), .addr_i(addr),
    .data_i(din), .data_o(dout), .data_valid_o(dvalid), .load_start_i(st),
    .load_valid_i(lv), .load_data_i(ld), .load_ready_o(lready), .load_busy_o(lbusy),
    .load_done_o(ldone)
  );
  assign perr = 1'b0;
`endif

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic          busy;
    logic          ready;
    logic          done;
    logic          perr;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: plain memory image, loader as "downloading or not" plus next index.
  logic [DW-1:0] m   [DEP];
  bit            bad [DEP];
  bit            loading = 0;
  int            laddr   = 0;

  function automatic logic [DW-1:0] boot_val(input int i);
    logic [DW-1:0] r;
    r = (i == 0) ? 4'hE : (i == 1) ? 4'h5 : (i == 2) ? 4'h8 : 4'h0;
    return r;
  endfunction

  // Predict the outputs after this edge from the inputs sampled at it, then update the image.
  task automatic model_edge();
    exp_t e;
    bit   was;
    e = '0;
    if (reset) begin
      for (int i = 0; i < DEP; i++) begin
        m[i]   = boot_val(i);
        bad[i] = 0;
      end
      loading = 0;
      laddr   = 0;
    end else begin
      was = loading;
      if (!was && rd) begin
        e.v = 1'b1;
        if (int'(addr) < DEP) begin
          e.d    = m[addr];
          e.perr = bad[addr];
        end
      end
      if (was) begin
        if (lv) begin
          m[laddr]   = ld;
          bad[laddr] = 0;
          if (laddr == DEP - 1) begin
            loading = 0;
            laddr   = 0;
            e.done  = 1'b1;
          end else begin
            laddr++;
          end
        end
      end else begin
        if (we && int'(addr) < DEP) begin
          m[addr]   = din;
          bad[addr] = 0;
        end
        if (st) begin
          loading = 1;
          laddr   = 0;
        end
      end
      e.busy  = loading;
      e.ready = loading;
    end
    q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic w, input logic rdn, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic s, input logic v, input logic [DW-1:0] l);
    reset = r; we = w; rd = rdn; addr = a; din = d; st = s; lv = v; ld = l;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, '0, '0, 0, 0, '0);
  endtask

  task automatic rd_at(input logic [AW-1:0] a);
    cyc(0, 0, 1, a, '0, 0, 0, '0);
  endtask

  // Monitor: pops one expectation per edge and compares all observed outputs.
  initial begin
    exp_t e, act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = '{v: dvalid, d: dout, busy: lbusy, ready: lready, done: ldone, perr: perr};
        n_chk++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL out_check t=%0t got v=%b d=%h busy=%b rdy=%b done=%b perr=%b exp v=%b d=%h busy=%b rdy=%b done=%b perr=%b",
                   $time, act.v, act.d, act.busy, act.ready, act.done, act.perr,
                   e.v, e.d, e.busy, e.ready, e.done, e.perr);
        end
      end
    end
  end

  initial begin
    reset = 1; we = 0; rd = 0; addr = '0; din = '0; st = 0; lv = 0; ld = '0;

    // Reset and boot program readback (addresses 0..4).
    cyc(1, 0, 0, '0, '0, 0, 0, '0);
    cyc(1, 0, 0, '0, '0, 0, 0, '0);
    for (int i = 0; i < 5; i++) rd_at(AW'(i));
    idle();

    // Plain write, then read-before-write on the same address.
    cyc(0, 1, 0, 4'd7, 4'hA, 0, 0, '0);
    rd_at(4'd7);
    cyc(0, 1, 1, 4'd7, 4'h3, 0, 0, '0);
    rd_at(4'd7);

    // Download 0..F with gaps, a locked-out CPU write/read and an ignored restart.
    cyc(0, 0, 0, '0, '0, 1, 0, '0);
    for (int i = 0; i < DEP; i++) begin
      if (i % 3 == 1) cyc(0, 0, 0, '0, '0, 0, 0, '0);
      if (i == 4)     cyc(0, 1, 1, 4'd2, 4'h9, 0, 0, '0);
      if (i == 8)     cyc(0, 0, 1, 4'd0, '0, 1, 0, '0);
      cyc(0, 0, 0, '0, '0, 0, 1, DW'(i));
    end
    idle();
    idle();
    for (int i = 0; i < DEP; i++) rd_at(AW'(i));

    // Reset after five words of a download restores the boot program.
    cyc(0, 0, 0, '0, '0, 1, 0, '0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, '0, '0, 0, 1, 4'hF - DW'(i));
    cyc(1, 0, 0, '0, '0, 0, 0, '0);
    for (int i = 0; i < 6; i++) rd_at(AW'(i));

`ifdef PROG_MEMORY_PARITY_EN
    // Corrupt a stored data bit behind the parity bit's back.
    dut.mem[1] = dut.mem[1] ^ 4'h1;
    m[1]       = m[1] ^ 4'h1;
    bad[1]     = 1;
    rd_at(4'd1);
    rd_at(4'd0);
    rd_at(4'd1);
`endif

    // Randomized traffic, including downloads and occasional resets.
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          AW'($urandom), DW'($urandom), ($urandom_range(0, 24) == 0),
          1'($urandom_range(0, 1)), DW'($urandom));
    end
    idle();

    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending entries exp 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
